// File: rtl/spectrum_upload_framer_pkg.sv
// Shared types and defaults for the spectrum upload framer and its helpers.
package spectrum_upload_framer_pkg;

  localparam int unsigned DIN_W           = 64;
  localparam int unsigned DOUT_W          = 32;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned FRAME_WORDS_DEF = 2048;
  localparam int unsigned SHIFT_DEF       = 16;
  localparam logic [DOUT_W-1:0] HDR_MAGIC_DEF = 32'hCCD1_5A5A;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    HDR0,
    HDR1,
    DATA,
    TAIL
  } state_t;

endpackage

// File: rtl/spectrum_upload_framer_sat.sv
// spectrum_sat_shift: registered 64->32 right-shift and saturate stage.
// Ports:
//   clk, rst   clock, async active-high reset
//   flush      discard the word being loaded this cycle (out_valid forced low)
//   in_valid   din qualifier
//   din        64-bit accumulated word
//   out_valid  registered qualifier for dout/sat
//   dout       (din >> SHIFT) clamped to 32 bits
//   sat        high when the shifted value did not fit in 32 bits
module spectrum_sat_shift
  import spectrum_upload_framer_pkg::*;
#(
  parameter int unsigned SHIFT = SHIFT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DIN_W-1:0]  din,
  output logic              out_valid,
  output logic [DOUT_W-1:0] dout,
  output logic              sat
);

  logic [DIN_W-1:0] shifted_c;
  logic             over_c;

  assign shifted_c = din >> SHIFT;
  assign over_c    = |shifted_c[DIN_W-1:DOUT_W];

  // Data/sat only load on a valid word so idle cycles do not toggle the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      sat       <= 1'b0;
    end else begin
      out_valid <= in_valid & ~flush;
      if (in_valid) begin
        sat  <= over_c;
        dout <= over_c ? '1 : shifted_c[DOUT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/spectrum_upload_framer.sv
// spectrum_upload_framer: frames one FRAME_WORDS burst of 64-bit accumulated
// spectrum words into a 32-bit stream: HDR_MAGIC, {frame_cnt, FRAME_WORDS},
// scaled/saturated data words, then a 32-bit wrapping checksum tail.
// Ports:
//   clk, rst       clock, async active-high reset
//   upload_en      low level aborts an open frame and idles the framer
//   trigger_start  single-cycle frame start (honoured only when armed)
//   din/din_valid  accumulated words, no backpressure
//   dout/dout_valid framed output stream
//   sof / eof      with header word 0 / with the tail word
//   sat_flag       with the tail: some word of this frame saturated
//   frame_cnt      completed frames, wraps
//   frame_abort    one-cycle pulse when a frame is cut by upload_en
//   err_overrun    sticky: din_valid outside the data window
//   err_trigger    sticky: trigger_start while a frame was open
module spectrum_upload_framer
  import spectrum_upload_framer_pkg::*;
#(
  parameter int unsigned       FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int unsigned       SHIFT       = SHIFT_DEF,
  parameter logic [DOUT_W-1:0] HDR_MAGIC   = HDR_MAGIC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upload_en,
  input  logic              trigger_start,
  input  logic [DIN_W-1:0]  din,
  input  logic              din_valid,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_valid,
  output logic              sof,
  output logic              eof,
  output logic              sat_flag,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              frame_abort,
  output logic              err_overrun,
  output logic              err_trigger
);

  localparam logic [CNT_W-1:0] FW = CNT_W'(FRAME_WORDS);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [DOUT_W-1:0]  cksum_q, cksum_d;
  logic               frame_sat_q, frame_sat_d;

  logic [DOUT_W-1:0]  dout_d;
  logic               dout_valid_d, sof_d, eof_d, sat_flag_d, frame_abort_d;
  logic               err_overrun_d, err_trigger_d;
  logic [CNT_W-1:0]   frame_cnt_d;

  logic               in_frame_c, abort_c, accept_c;
  logic               s1_valid, s1_sat;
  logic [DOUT_W-1:0]  s1_data;

  assign in_frame_c = state_q inside {HDR0, HDR1, DATA, TAIL};
  assign abort_c    = ~upload_en & (state_q != IDLE);
  assign accept_c   = din_valid & upload_en & (state_q == DATA) & (word_cnt_q != FW);

  // Pipeline stage 1: shift and saturate; abort discards the in-flight word.
  spectrum_sat_shift #(
    .SHIFT (SHIFT)
  ) u_sat (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort_c),
    .in_valid  (accept_c),
    .din       (din),
    .out_valid (s1_valid),
    .dout      (s1_data),
    .sat       (s1_sat)
  );

  // Next-state and next-output logic; the output register is stage 2.
  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    cksum_d       = cksum_q;
    frame_sat_d   = frame_sat_q;
    dout_d        = dout;
    dout_valid_d  = 1'b0;
    sof_d         = 1'b0;
    eof_d         = 1'b0;
    sat_flag_d    = 1'b0;
    frame_abort_d = 1'b0;
    frame_cnt_d   = frame_cnt;
    err_overrun_d = err_overrun | (din_valid & ~((state_q == DATA) & (word_cnt_q != FW)));
    err_trigger_d = err_trigger | (trigger_start & in_frame_c);

    // Stage 1 output feeds dout and the checksum in the same cycle.
    if (s1_valid) begin
      dout_d       = s1_data;
      dout_valid_d = 1'b1;
      cksum_d      = cksum_q + s1_data;
      frame_sat_d  = frame_sat_q | s1_sat;
    end

    unique case (state_q)
      IDLE: begin
        if (upload_en) state_d = ARMED;
      end
      ARMED: begin
        if (trigger_start) begin
          state_d      = HDR0;
          word_cnt_d   = '0;
          cksum_d      = '0;
          frame_sat_d  = 1'b0;
          dout_d       = HDR_MAGIC;
          dout_valid_d = 1'b1;
          sof_d        = 1'b1;
        end
      end
      HDR0: begin
        state_d      = HDR1;
        dout_d       = {frame_cnt, FW};
        dout_valid_d = 1'b1;
      end
      HDR1: begin
        state_d = DATA;
      end
      DATA: begin
        if (accept_c) begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (word_cnt_q + CNT_W'(1) == FW) state_d = TAIL;
        end
      end
      TAIL: begin
        // Wait for the last word to leave stage 1 so the checksum is complete.
        if (!s1_valid) begin
          dout_d       = cksum_q;
          dout_valid_d = 1'b1;
          eof_d        = 1'b1;
          sat_flag_d   = frame_sat_q;
          frame_cnt_d  = frame_cnt + CNT_W'(1);
          state_d      = ARMED;
        end
      end
      default: state_d = IDLE;
    endcase

    // Losing upload_en overrides everything: flush, no tail, count untouched.
    if (abort_c) begin
      state_d       = IDLE;
      dout_d        = dout;
      dout_valid_d  = 1'b0;
      sof_d         = 1'b0;
      eof_d         = 1'b0;
      sat_flag_d    = 1'b0;
      frame_cnt_d   = frame_cnt;
      frame_abort_d = in_frame_c;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      cksum_q     <= '0;
      frame_sat_q <= 1'b0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      sof         <= 1'b0;
      eof         <= 1'b0;
      sat_flag    <= 1'b0;
      frame_cnt   <= '0;
      frame_abort <= 1'b0;
      err_overrun <= 1'b0;
      err_trigger <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      cksum_q     <= cksum_d;
      frame_sat_q <= frame_sat_d;
      dout        <= dout_d;
      dout_valid  <= dout_valid_d;
      sof         <= sof_d;
      eof         <= eof_d;
      sat_flag    <= sat_flag_d;
      frame_cnt   <= frame_cnt_d;
      frame_abort <= frame_abort_d;
      err_overrun <= err_overrun_d;
      err_trigger <= err_trigger_d;
    end
  end

endmodule

// File: tb/tb_spectrum_upload_framer.sv
// Self-checking bench for spectrum_upload_framer: directed frames, an
// event-level output model scheduled from the stimulus, and literal pins.
module tb_spectrum_upload_framer;

  localparam int          FW    = 2048;
  localparam logic [31:0] MAGIC = 32'hCCD1_5A5A;
  localparam int          NC    = 16384;

  logic        clk = 1'b0;
  logic        rst, upload_en, trigger_start, din_valid;
  logic [63:0] din;
  logic [31:0] dout;
  logic        dout_valid, sof, eof, sat_flag, frame_abort, err_overrun, err_trigger;
  logic [15:0] frame_cnt;

  spectrum_upload_framer dut (
    .clk           (clk),
    .rst           (rst),
    .upload_en     (upload_en),
    .trigger_start (trigger_start),
    .din           (din),
    .din_valid     (din_valid),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .sof           (sof),
    .eof           (eof),
    .sat_flag      (sat_flag),
    .frame_cnt     (frame_cnt),
    .frame_abort   (frame_abort),
    .err_overrun   (err_overrun),
    .err_trigger   (err_trigger)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs per cycle, scheduled by the model.
  bit          e_v   [NC];
  logic [31:0] e_d   [NC];
  bit          e_sof [NC];
  bit          e_eof [NC];
  bit          e_sat [NC];
  bit          e_ab  [NC];
  bit          e_fc  [NC];

  int total = 0;
  int bad   = 0;

  // Model: 0 idle, 1 armed, 2 frame open.
  int          m_mode = 0;
  int          m_t    = 0;
  int          m_cnt  = 0;
  int          m_done = -1;
  logic [31:0] m_sum  = '0;
  bit          m_sat  = 1'b0;
  logic [15:0] m_fc   = '0;

  bit          chk_en  = 1'b0;
  int          fc_vis  = 0;
  int          ab_seen = 0;
  bit          prev_sof = 1'b0;
  logic [31:0] tail_log [$];
  bit          sat_log  [$];
  logic [31:0] hdr1_log [$];

  function automatic logic [32:0] scale(input logic [63:0] x);
    logic [63:0] q;
    q = x / 64'd65536;
    if (q > 64'h0000_0000_FFFF_FFFF) return {1'b1, 32'hFFFF_FFFF};
    return {1'b0, q[31:0]};
  endfunction

  function automatic logic [31:0] tail_at(input int i);
    return (i < tail_log.size()) ? tail_log[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic sat_at(input int i);
    return (i < sat_log.size()) ? sat_log[i] : 1'bx;
  endfunction

  function automatic logic [31:0] hdr1_at(input int i);
    return (i < hdr1_log.size()) ? hdr1_log[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [63:0] word_of(input int mode, input int i);
    case (mode)
      1:       return (i == 5) ? 64'h0001_0000_0000_0000 : (64'(i) << 16);
      2:       return (i == 10) ? 64'h0000_FFFF_FFFF_FFFF : (((64'(i) * 64'd977) << 16) | 64'hABCD);
      default: return 64'(i) << 16;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, 64'({dout, dout_valid, sof, eof, sat_flag, frame_cnt, frame_abort,
                     err_overrun, err_trigger}), 64'd0);
  endtask

  task automatic sched(input int c, input logic [31:0] d, input bit s, input bit e, input bit st);
    if (c < NC) begin
      e_v[c] = 1'b1; e_d[c] = d; e_sof[c] = s; e_eof[c] = e; e_sat[c] = st;
    end
  endtask

  task automatic clear_from(input int c, input int n);
    for (int k = 0; k < n; k++) begin
      if (c + k < NC) begin
        e_v[c+k] = 1'b0; e_sof[c+k] = 1'b0; e_eof[c+k] = 1'b0;
        e_sat[c+k] = 1'b0; e_fc[c+k] = 1'b0;
      end
    end
  endtask

  // Translate one cycle of stimulus into scheduled expected outputs.
  task automatic model_step(input bit en, input bit trig, input bit v, input logic [63:0] d);
    int c;
    logic [32:0] r;
    c = cyc;
    if (m_mode != 0 && !en) begin
      if (m_mode == 2) begin
        if (c + 1 < NC) e_ab[c+1] = 1'b1;
        clear_from(c + 1, 4);
        if (m_done >= 0) m_fc = m_fc - 16'd1;
      end
      m_mode = 0;
      return;
    end
    case (m_mode)
      0: if (en) m_mode = 1;
      1: if (trig) begin
        m_t = c; m_cnt = 0; m_sum = '0; m_sat = 1'b0; m_done = -1; m_mode = 2;
        sched(c + 1, MAGIC, 1'b1, 1'b0, 1'b0);
        sched(c + 2, {m_fc, 16'(FW)}, 1'b0, 1'b0, 1'b0);
      end
      default: begin
        if (v && c >= m_t + 3 && m_cnt < FW) begin
          r = scale(d);
          sched(c + 2, r[31:0], 1'b0, 1'b0, 1'b0);
          m_sum = m_sum + r[31:0];
          m_sat = m_sat | r[32];
          m_cnt++;
          if (m_cnt == FW) begin
            m_done = c;
            sched(c + 3, m_sum, 1'b0, 1'b1, m_sat);
            if (c + 3 < NC) e_fc[c+3] = 1'b1;
            m_fc = m_fc + 16'd1;
          end
        end
        if (m_done >= 0 && c == m_done + 2) m_mode = 1;
      end
    endcase
  endtask

  task automatic model_reset();
    clear_from(cyc, 6);
    for (int k = 0; k < 6; k++) if (cyc + k < NC) e_ab[cyc+k] = 1'b0;
    m_mode = 0; m_fc = '0; m_done = -1;
    chk_en = 1'b0;
  endtask

  task automatic cyc_drive(input bit en, input bit trig, input bit v, input logic [63:0] d);
    @(posedge clk); #1;
    upload_en = en; trigger_start = trig; din_valid = v; din = d;
    model_step(en, trig, v, d);
  endtask

  task automatic run_frame(input int mode, input int abort_at, input int rst_at);
    cyc_drive(1'b1, 1'b1, 1'b0, 64'd0);
    cyc_drive(1'b1, 1'b0, (mode == 2), 64'hDEAD_0000_0000);
    cyc_drive(1'b1, 1'b0, 1'b0, 64'd0);
    cyc_drive(1'b1, 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < FW; i++) begin
      if (i == abort_at) begin
        cyc_drive(1'b0, 1'b0, 1'b0, 64'd0);
        return;
      end
      if (mode == 1 && i % 7 == 3) cyc_drive(1'b1, 1'b0, 1'b0, 64'd0);
      cyc_drive(1'b1, (mode == 1 && i == 300), 1'b1, word_of(mode, i));
      if (i == rst_at) begin
        #1 rst = 1'b1;
        model_reset();
        #1 check_zero("async_reset_outputs");
        return;
      end
    end
    cyc_drive(1'b1, 1'b0, (mode == 2), word_of(mode, FW));
    cyc_drive(1'b1, 1'b0, 1'b0, 64'd0);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!chk_en || cyc >= NC) begin
      fc_vis   = 0;
      prev_sof = 1'b0;
    end else begin
      if (e_fc[cyc]) fc_vis++;
      total++;
      if (dout_valid !== e_v[cyc] || (e_v[cyc] && dout !== e_d[cyc]) ||
          sof !== e_sof[cyc] || eof !== e_eof[cyc] ||
          sat_flag !== (e_eof[cyc] & e_sat[cyc]) || frame_abort !== e_ab[cyc] ||
          frame_cnt !== 16'(fc_vis)) begin
        bad++;
        $display("FAIL cycle %0d stream: got v=%b d=%h sof=%b eof=%b sat=%b ab=%b fc=%0d want v=%b d=%h sof=%b eof=%b sat=%b ab=%b fc=%0d",
                 cyc, dout_valid, dout, sof, eof, sat_flag, frame_abort, frame_cnt,
                 e_v[cyc], e_d[cyc], e_sof[cyc], e_eof[cyc], e_eof[cyc] & e_sat[cyc],
                 e_ab[cyc], fc_vis);
      end
      if (eof) begin
        tail_log.push_back(dout);
        sat_log.push_back(sat_flag);
      end
      if (prev_sof && dout_valid) hdr1_log.push_back(dout);
      if (frame_abort) ab_seen++;
      prev_sof = sof;
    end
  end

  initial begin
    rst = 1'b1; upload_en = 1'b0; trigger_start = 1'b0; din_valid = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset_state");
    rst = 1'b0; chk_en = 1'b1;

    // Trigger while idle: ignored without raising err_trigger.
    cyc_drive(1'b0, 1'b1, 1'b0, 64'd0);
    cyc_drive(1'b0, 1'b0, 1'b0, 64'd0);
    check("idle_trigger_silent", 64'(err_trigger), 64'd0);

    cyc_drive(1'b1, 1'b0, 1'b0, 64'd0);
    cyc_drive(1'b1, 1'b0, 1'b0, 64'd0);
    run_frame(0, -1, -1);
    check("err_trigger_clean", 64'(err_trigger), 64'd0);
    // Back-to-back: next trigger lands on the tail cycle, first ARMED cycle.
    run_frame(1, -1, -1);
    repeat (3) cyc_drive(1'b1, 1'b0, 1'b0, 64'd0);
    check("tail_count_2",  64'(tail_log.size()), 64'd2);
    check("tail_nominal",  64'(tail_at(0)), 64'h001F_FC00);
    check("sat_nominal",   64'(sat_at(0)), 64'd0);
    check("tail_sat",      64'(tail_at(1)), 64'h001F_FBFA);
    check("sat_flag_set",  64'(sat_at(1)), 64'd1);
    check("hdr1_frame0",   64'(hdr1_at(0)), 64'h0000_0800);
    check("hdr1_frame1",   64'(hdr1_at(1)), 64'h0001_0800);
    check("frame_cnt_2",   64'(frame_cnt), 64'd2);
    check("err_trigger_stray", 64'(err_trigger), 64'd1);
    check("err_overrun_clean", 64'(err_overrun), 64'd0);

    // Boundary word, din_valid in HDR0 and a 2049th word.
    run_frame(2, -1, -1);
    repeat (3) cyc_drive(1'b1, 1'b0, 1'b0, 64'd0);
    check("tail_boundary",  64'(tail_at(2)), 64'h7A10_95D5);
    check("sat_boundary",   64'(sat_at(2)), 64'd0);
    check("err_overrun_set", 64'(err_overrun), 64'd1);
    check("frame_cnt_3",    64'(frame_cnt), 64'd3);

    // Abort after 100 words; a trigger after the abort must not start a frame.
    run_frame(0, 100, -1);
    repeat (4) cyc_drive(1'b0, 1'b0, 1'b0, 64'd0);
    cyc_drive(1'b0, 1'b1, 1'b0, 64'd0);
    repeat (4) cyc_drive(1'b0, 1'b0, 1'b0, 64'd0);
    check("abort_pulses",     64'(ab_seen), 64'd1);
    check("frame_cnt_abort",  64'(frame_cnt), 64'd3);
    check("tail_count_abort", 64'(tail_log.size()), 64'd3);

    // Async reset in the middle of DATA.
    cyc_drive(1'b1, 1'b0, 1'b0, 64'd0);
    cyc_drive(1'b1, 1'b0, 1'b0, 64'd0);
    run_frame(0, -1, 50);
    cyc_drive(1'b0, 1'b0, 1'b0, 64'd0);
    cyc_drive(1'b0, 1'b0, 1'b0, 64'd0);
    cyc_drive(1'b0, 1'b0, 1'b0, 64'd0);
    rst = 1'b0; chk_en = 1'b1;
    check_zero("post_reset_state");

    cyc_drive(1'b1, 1'b0, 1'b0, 64'd0);
    cyc_drive(1'b1, 1'b0, 1'b0, 64'd0);
    cyc_drive(1'b1, 1'b1, 1'b0, 64'd0);
    repeat (4) cyc_drive(1'b1, 1'b0, 1'b0, 64'd0);
    check("hdr1_after_reset", 64'(hdr1_at(hdr1_log.size() - 1)), 64'h0000_0800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
